mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V core, sitting between the EX/MEM pipeline register and the word-indexed data `ram`. It accepts one load/store/pass-through op per cycle from EX and converts byte addresses to word indices. It drives the `ram` control flags, extracts and sign-extends load lanes from the returned word, and performs sub-word stores as a 2-cycle read-modify-write. It registers the result into the MEM/WB stage.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: full-word ram accesses, load lane extract, sub-word store RMW; MEM_STAGE_MISALIGN_TRAP_EN traps misalignment.
// Latency 1 cycle (load/sw/pass/fault), 2 cycles sb/sh; in_ready drops for the RMW cycle, MEM/WB never stalls.
module mem_stage #(
    parameter int unsigned RAM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_result,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic [31:0] ram_addr,
    output logic [31:0] write_ram_data,
    output logic [1:0]  write_ram_flag,
    output logic [2:0]  read_ram_flag,
    input  logic [31:0] ram_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [31:0] fault_addr
);
    typedef enum logic {IDLE, RMW} state_t;
    state_t state, state_nxt;

    logic        accept, is_mem, is_word, is_half, f3_bad, range_bad, misalign, op_fault;
    logic [1:0]  off;
    logic [31:0] lane, load_val, merge_mask, merged;

    logic [31:0] rmw_word;
    logic [15:0] rmw_wdata;
    logic [1:0]  rmw_off;
    logic        rmw_half;
    logic [29:0] rmw_idx;
    logic [4:0]  rmw_rd;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_mem    = in_is_load | in_is_store;
        is_word   = (in_funct3[1:0] == 2'b10);
        is_half   = (in_funct3[1:0] == 2'b01);
        f3_bad    = 1'b0;
        if (in_is_load)
            f3_bad = (in_funct3[1:0] == 2'b11) || (in_funct3 == 3'b110);
        else if (in_is_store)
            f3_bad = in_funct3[2] || (in_funct3[1:0] == 2'b11);
        range_bad = is_mem && ({2'b00, in_addr[31:2]} >= 32'(RAM_WORDS));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        misalign  = is_mem && ((is_word && in_addr[1:0] != 2'b00) || (is_half && in_addr[0]));
        off       = in_addr[1:0];
`else
        misalign  = 1'b0;
        // Without the trap, low address bits are masked to natural alignment.
        off       = is_word ? 2'b00 : (is_half ? {in_addr[1], 1'b0} : in_addr[1:0]);
`endif
        op_fault  = (in_is_load && in_is_store) || f3_bad || range_bad || misalign;
    end

    always_comb begin
        lane = ram_out >> {off, 3'b000};
        case (in_funct3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = ram_out;
        endcase
        merge_mask = (rmw_half ? 32'h0000_FFFF : 32'h0000_00FF) << {rmw_off, 3'b000};
        merged     = (rmw_word & ~merge_mask) | (({16'h0, rmw_wdata} << {rmw_off, 3'b000}) & merge_mask);
    end

    always_comb begin
        state_nxt      = state;
        ram_addr       = 32'h0;
        write_ram_data = 32'h0;
        write_ram_flag = 2'b00;
        read_ram_flag  = 3'b000;
        case (state)
            IDLE: begin
                if (accept && is_mem && !op_fault) begin
                    ram_addr = {2'b00, in_addr[31:2]};
                    if (in_is_load) begin
                        read_ram_flag = 3'b001;
                    end else if (is_word) begin
                        write_ram_flag = 2'b01;
                        write_ram_data = in_wdata;
                    end else begin
                        read_ram_flag = 3'b001;
                        state_nxt     = RMW;
                    end
                end
            end
            RMW: begin
                // Reset here drops the pending write; the op is lost.
                if (!rst) begin
                    ram_addr       = {2'b00, rmw_idx};
                    write_ram_flag = 2'b01;
                    write_ram_data = merged;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'h0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0;
            fault        <= 1'b0;
            fault_addr   <= 32'h0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            if (state == RMW) begin
                wb_valid     <= 1'b1;
                wb_rd        <= rmw_rd;
                wb_reg_write <= 1'b0;
            end else if (accept) begin
                if (op_fault) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= in_rd;
                    wb_reg_write <= 1'b0;
                    wb_data      <= 32'h0;
                    fault        <= 1'b1;
                    fault_addr   <= in_addr;
                end else if (in_is_load) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= in_rd;
                    wb_reg_write <= in_reg_write;
                    wb_data      <= load_val;
                end else if (in_is_store && is_word) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= in_rd;
                    wb_reg_write <= 1'b0;
                end else if (in_is_store) begin
                    rmw_word  <= ram_out;
                    rmw_wdata <= in_wdata[15:0];
                    rmw_off   <= off;
                    rmw_half  <= is_half;
                    rmw_idx   <= in_addr[31:2];
                    rmw_rd    <= in_rd;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= in_rd;
                    wb_reg_write <= in_reg_write;
                    wb_data      <= in_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed reference memory model, directed cases then random ops.
module tb_mem_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_is_load, in_is_store, in_reg_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_result;
    logic [4:0]  in_rd;
    logic [31:0] ram_addr, write_ram_data, ram_out;
    logic [1:0]  write_ram_flag;
    logic [2:0]  read_ram_flag;
    logic        wb_valid, wb_reg_write, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr;

    mem_stage #(.RAM_WORDS(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .ram_addr(ram_addr), .write_ram_data(write_ram_data), .write_ram_flag(write_ram_flag),
        .read_ram_flag(read_ram_flag), .ram_out(ram_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fault(fault), .fault_addr(fault_addr)
    );

    // Environment RAM (combinational read, write on posedge) and the reference image.
    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic        pre_we;
    logic [6:0]  pre_addr;
    logic [31:0] pre_data;

    assign ram_out = (ram_addr < 32'd128) ? mem[ram_addr[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (write_ram_flag == 2'b01 && ram_addr < 32'd128) mem[ram_addr[6:0]] <= write_ram_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_byte(input int unsigned a);
        return ref_mem[a / 4][8 * (a % 4) +: 8];
    endfunction

    function automatic void ref_set_byte(input int unsigned a, input logic [7:0] b);
        ref_mem[a / 4][8 * (a % 4) +: 8] = b;
    endfunction

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] result, input logic [4:0] rd,
                          input logic rw, input string tag);
        int unsigned size, a;
        logic        legal, exp_fault;
        longint      val;
        logic [31:0] exp_data;
        size  = 32'd1 << f3[1:0];
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                   : (st ? (f3 inside {3'd0, 3'd1, 3'd2}) : 1'b1);
        exp_fault = (ld || st) && ((ld && st) || !legal || (addr / 4 >= 128));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if ((ld || st) && legal && (addr % size) != 0) exp_fault = 1'b1;
`endif
        a        = addr - (addr % size);
        exp_data = 32'h0;
        if (ld && !exp_fault) begin
            val = 0;
            for (int i = 0; i < int'(size); i++) val = val | (longint'(ref_byte(a + i)) << (8 * i));
            if (!f3[2] && val[8 * size - 1]) val = val - (longint'(1) << (8 * size));
            exp_data = val[31:0];
        end

        @(negedge clk);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_result = result; in_rd = rd; in_reg_write = rw;
        #1;
        if (exp_fault || !(ld || st)) begin
            check({tag, ".noflags"}, {27'h0, read_ram_flag, write_ram_flag}, 32'h0);
        end else if (ld || size < 4) begin
            check({tag, ".rdflag"}, {29'h0, read_ram_flag}, 32'h1);
            check({tag, ".ramaddr"}, ram_addr, a / 4);
        end else begin
            check({tag, ".wrflag"}, {30'h0, write_ram_flag}, 32'h1);
            check({tag, ".wrdata"}, write_ram_data, wdata);
        end
        @(posedge clk); #1;
        if (st && !exp_fault) begin
            for (int i = 0; i < int'(size); i++) ref_set_byte(a + i, wdata[8 * i +: 8]);
            if (size < 4) begin
                check({tag, ".rmw_ready"}, {31'h0, in_ready}, 32'h0);
                check({tag, ".rmw_wbvalid"}, {31'h0, wb_valid}, 32'h0);
                check({tag, ".rmw_wrflag"}, {30'h0, write_ram_flag}, 32'h1);
                check({tag, ".rmw_data"}, write_ram_data, ref_mem[a / 4]);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        check({tag, ".wbvalid"}, {31'h0, wb_valid}, 32'h1);
        check({tag, ".fault"}, {31'h0, fault}, {31'h0, exp_fault});
        if (exp_fault) begin
            check({tag, ".faddr"}, fault_addr, addr);
            check({tag, ".fdata"}, wb_data, 32'h0);
            check({tag, ".frw"}, {31'h0, wb_reg_write}, 32'h0);
        end else if (ld) begin
            check({tag, ".data"}, wb_data, exp_data);
            check({tag, ".rw"}, {31'h0, wb_reg_write}, {31'h0, rw});
            check({tag, ".rd"}, {27'h0, wb_rd}, {27'h0, rd});
        end else if (st) begin
            check({tag, ".st_rw"}, {31'h0, wb_reg_write}, 32'h0);
            check({tag, ".memword"}, mem[a / 4], ref_mem[a / 4]);
        end else begin
            check({tag, ".pdata"}, wb_data, result);
            check({tag, ".prw"}, {31'h0, wb_reg_write}, {31'h0, rw});
            check({tag, ".prd"}, {27'h0, wb_rd}, {27'h0, rd});
        end
    endtask

    initial begin
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r;
        rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'h0;
        in_addr = 32'h0; in_wdata = 32'h0; in_result = 32'h0; in_rd = 5'h0; in_reg_write = 1'b0;
        pre_we = 1'b0; pre_addr = 7'h0; pre_data = 32'h0;

        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = (i == 5) ? 32'h8765_4321 : $urandom;
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 7'(i); pre_data = ref_mem[i];
        end
        @(negedge clk); pre_we = 1'b0;
        @(posedge clk); #1;
        check("rst.ready", {31'h0, in_ready}, 32'h0);
        check("rst.wbvalid", {31'h0, wb_valid}, 32'h0);
        check("rst.rw", {31'h0, wb_reg_write}, 32'h0);
        check("rst.fault", {31'h0, fault}, 32'h0);
        check("rst.rd", {27'h0, wb_rd}, 32'h0);
        check("rst.data", wb_data, 32'h0);
        check("rst.faddr", fault_addr, 32'h0);
        check("rst.flags", {27'h0, read_ram_flag, write_ram_flag}, 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        check("ready_after_rst", {31'h0, in_ready}, 32'h1);

        run_op(1, 0, 3'b010, 32'h14, 32'h0, 32'h0, 5'd3, 1, "lw14");
        check("lw14.const", wb_data, 32'h8765_4321);
        run_op(1, 0, 3'b000, 32'h17, 32'h0, 32'h0, 5'd4, 1, "lb17");
        check("lb17.const", wb_data, 32'hFFFF_FF87);
        run_op(1, 0, 3'b100, 32'h17, 32'h0, 32'h0, 5'd5, 1, "lbu17");
        check("lbu17.const", wb_data, 32'h0000_0087);
        run_op(1, 0, 3'b001, 32'h16, 32'h0, 32'h0, 5'd6, 1, "lh16");
        check("lh16.const", wb_data, 32'hFFFF_8765);
        run_op(0, 1, 3'b000, 32'h15, 32'hAA, 32'h0, 5'd7, 1, "sb15");
        run_op(1, 0, 3'b010, 32'h14, 32'h0, 32'h0, 5'd8, 1, "lw14b");
        check("lw14b.const", wb_data, 32'h8765_AA21);

        // Reset lands in the RMW cycle of sh: the write must be suppressed.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_funct3 = 3'b001;
        in_addr = 32'h14; in_wdata = 32'hBEEF; in_rd = 5'd9; in_reg_write = 1'b1;
        @(posedge clk); #1;
        check("rstrmw.ready", {31'h0, in_ready}, 32'h0);
        rst = 1'b1; #1;
        check("rstrmw.wrflag", {30'h0, write_ram_flag}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstrmw.wbvalid", {31'h0, wb_valid}, 32'h0);
        check("rstrmw.wbdata", wb_data, 32'h0);
        check("rstrmw.wbrd", {27'h0, wb_rd}, 32'h0);
        check("rstrmw.wbrw", {31'h0, wb_reg_write}, 32'h0);
        check("rstrmw.mem5", mem[5], 32'h8765_AA21);
        @(negedge clk); rst = 1'b0;

        run_op(1, 0, 3'b010, 32'h16, 32'h0, 32'h0, 5'd10, 1, "lw16");
        run_op(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd11, 1, "lw200");
        check("lw200.fault", {31'h0, fault}, 32'h1);
        run_op(1, 0, 3'b011, 32'h14, 32'h0, 32'h0, 5'd12, 1, "ld011");
        check("ld011.fault", {31'h0, fault}, 32'h1);
        run_op(1, 1, 3'b010, 32'h14, 32'h0, 32'h0, 5'd13, 1, "ldst");
        run_op(0, 0, 3'b111, 32'hFFFF_FFF0, 32'h0, 32'hCAFE_F00D, 5'd14, 1, "pass");
        run_op(0, 1, 3'b010, 32'h18, 32'h1234_5678, 32'h0, 5'd15, 1, "sw18");
        run_op(0, 1, 3'b001, 32'h1A, 32'h0000_BEEF, 32'h0, 5'd16, 1, "sh1a");

        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            ld = (r <= 3) || (r == 9);
            st = (r >= 4 && r <= 6) || (r == 9);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31));
            run_op(ld, st, f3, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), "rand");
        end

        for (int i = 0; i < 128; i++) check("final.mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
